// File: rtl/cb_seg_calc.sv
// Turbo code-block segmentation (C, K+/K-, C+/C-, F) for a CRC-attached TB size; optional err_cnt via CB_SEG_ERR_CNT_EN.
// Iterative, variable latency; one request at a time, result held in DONE until out_ready.
module cb_seg_calc #(
    parameter int B_W   = 16,
    parameter int Z     = 6144,
    parameter int L     = 24,
    parameter int MAX_C = 8,
    parameter int C_W   = $clog2(MAX_C + 1)
) (
    input  logic           clk,
    input  logic           aclr,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [B_W-1:0] b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [C_W-1:0] c_out,
    output logic [C_W-1:0] c_plus,
    output logic [C_W-1:0] c_minus,
    output logic [12:0]    k_plus,
    output logic [12:0]    k_minus,
    output logic [B_W-1:0] filler,
    output logic           err,
    output logic [15:0]    err_cnt
);

    // Wide enough for C*K and B+C*L without truncation.
    localparam int P_W = ((B_W > 13) ? B_W : 13) + C_W;
    localparam logic [B_W-1:0] Z_B  = B_W'(Z);
    localparam logic [B_W-1:0] ZL_B = B_W'(Z - L);

    typedef enum logic [2:0] {IDLE, DIVC, KSRCH, SPLIT, FILL, DONE} state_t;

    state_t         state;
    logic [B_W-1:0] b_q;
    logic [B_W-1:0] rem;
    logic [C_W-1:0] c_q;
    logic [C_W-1:0] cm_q;
    logic [P_W-1:0] bp;
    logic [P_W-1:0] diff;
    logic [12:0]    k;
    logic [12:0]    km_q;
    logic [12:0]    dk;

    function automatic logic [12:0] next_k(input logic [12:0] kk);
        if (kk < 13'd512)       return kk + 13'd8;
        else if (kk < 13'd1024) return kk + 13'd16;
        else if (kk < 13'd2048) return kk + 13'd32;
        else                    return kk + 13'd64;
    endfunction

    function automatic logic [12:0] prev_k(input logic [12:0] kk);
        if (kk <= 13'd512)       return kk - 13'd8;
        else if (kk <= 13'd1024) return kk - 13'd16;
        else if (kk <= 13'd2048) return kk - 13'd32;
        else                     return kk - 13'd64;
    endfunction

    logic [C_W-1:0] cn;
    logic [C_W-1:0] cp_w;
    logic [P_W-1:0] prod;
    logic [P_W-1:0] fill_w;
    logic [12:0]    kpv;
    logic           one_blk;
    logic           div_err;

    always_comb begin
        cn      = c_q + C_W'(1);
        cp_w    = c_q - cm_q;
        prod    = P_W'(c_q) * P_W'(k);
        fill_w  = P_W'(cp_w) * P_W'(k) + P_W'(cm_q) * P_W'(km_q) - bp;
        kpv     = prev_k(k);
        one_blk = (c_q == '0) && (b_q <= Z_B);
        // Abort before C can exceed MAX_C: remainder still too big after MAX_C-1 subtractions.
        div_err = (b_q == '0) || (!one_blk && (rem > ZL_B) && (cn >= C_W'(MAX_C)));
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            err       <= 1'b0;
            c_out     <= '0;
            c_plus    <= '0;
            c_minus   <= '0;
            k_plus    <= '0;
            k_minus   <= '0;
            filler    <= '0;
            b_q       <= '0;
            rem       <= '0;
            c_q       <= '0;
            cm_q      <= '0;
            bp        <= '0;
            diff      <= '0;
            k         <= '0;
            km_q      <= '0;
            dk        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        b_q      <= b_in;
                        rem      <= b_in;
                        c_q      <= '0;
                        in_ready <= 1'b0;
                        state    <= DIVC;
                    end
                end
                DIVC: begin
                    if (div_err) begin
                        err       <= 1'b1;
                        c_out     <= '0;
                        c_plus    <= '0;
                        c_minus   <= '0;
                        k_plus    <= '0;
                        k_minus   <= '0;
                        filler    <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (one_blk) begin
                        c_q   <= C_W'(1);
                        bp    <= P_W'(b_q);
                        k     <= 13'd40;
                        state <= KSRCH;
                    end else if (rem <= ZL_B) begin
                        c_q   <= cn;
                        bp    <= P_W'(b_q) + P_W'(cn) * P_W'(L);
                        k     <= 13'd40;
                        state <= KSRCH;
                    end else begin
                        rem <= rem - ZL_B;
                        c_q <= cn;
                    end
                end
                KSRCH: begin
                    if ((prod >= bp) || (k >= 13'(Z))) begin
                        km_q  <= kpv;
                        dk    <= k - kpv;
                        diff  <= prod - bp;
                        cm_q  <= '0;
                        state <= SPLIT;
                    end else begin
                        k <= next_k(k);
                    end
                end
                SPLIT: begin
                    if (c_q == C_W'(1)) begin
                        km_q  <= '0;
                        state <= FILL;
                    end else if (diff >= P_W'(dk)) begin
                        diff <= diff - P_W'(dk);
                        cm_q <= cm_q + C_W'(1);
                    end else begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    err       <= 1'b0;
                    c_out     <= c_q;
                    c_plus    <= cp_w;
                    c_minus   <= cm_q;
                    k_plus    <= k;
                    k_minus   <= km_q;
                    filler    <= fill_w[B_W-1:0];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CB_SEG_ERR_CNT_EN
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            err_cnt <= '0;
        else if (out_valid && out_ready && err && (err_cnt != 16'hFFFF))
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_cb_seg_calc.sv
// Scoreboard bench for cb_seg_calc: expected results queued at stimulus time, compared when out_valid appears.
module tb_cb_seg_calc;

    logic        clk = 1'b0;
    logic        aclr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  c_out, c_plus, c_minus;
    logic [12:0] k_plus, k_minus;
    logic [15:0] filler;
    logic        err;
    logic [15:0] err_cnt;

    always #5 clk = ~clk;

    cb_seg_calc dut (
        .clk(clk), .aclr(aclr), .in_valid(in_valid), .in_ready(in_ready), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .c_out(c_out), .c_plus(c_plus),
        .c_minus(c_minus), .k_plus(k_plus), .k_minus(k_minus), .filler(filler),
        .err(err), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic        err;
        logic [3:0]  c, cp, cm;
        logic [12:0] kp, km;
        logic [15:0] f;
    } res_t;

    res_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_err_cnt = 0;

    function automatic res_t mk(input logic e, input int c, input int cp, input int cm,
                                input int kp, input int km, input int f);
        res_t r;
        r.err = e; r.c = 4'(c); r.cp = 4'(cp); r.cm = 4'(cm);
        r.kp = 13'(kp); r.km = 13'(km); r.f = 16'(f);
        return r;
    endfunction

    function automatic res_t observe();
        return {err, c_out, c_plus, c_minus, k_plus, k_minus, filler};
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("err=%0d C=%0d C+=%0d C-=%0d K+=%0d K-=%0d F=%0d",
                         r.err, r.c, r.cp, r.cm, r.kp, r.km, r.f);
    endfunction

    // Smallest interleaver size >= x.
    function automatic int tbl_ceil(input int x);
        for (int kk = 40;   kk <= 512;  kk += 8)  if (kk >= x) return kk;
        for (int kk = 528;  kk <= 1024; kk += 16) if (kk >= x) return kk;
        for (int kk = 1056; kk <= 2048; kk += 32) if (kk >= x) return kk;
        for (int kk = 2112; kk <= 6144; kk += 64) if (kk >= x) return kk;
        return 6144;
    endfunction

    // Largest interleaver size strictly below x.
    function automatic int tbl_below(input int x);
        int best = 0;
        for (int kk = 40;   kk <= 512;  kk += 8)  if (kk < x) best = kk;
        for (int kk = 528;  kk <= 1024; kk += 16) if (kk < x) best = kk;
        for (int kk = 1056; kk <= 2048; kk += 32) if (kk < x) best = kk;
        for (int kk = 2112; kk <= 6144; kk += 64) if (kk < x) best = kk;
        return best;
    endfunction

    function automatic res_t model(input int b);
        int c, bp, kp, km, cm, cp;
        if (b == 0) return mk(1'b1, 0, 0, 0, 0, 0, 0);
        c = (b <= 6144) ? 1 : (b + 6119) / 6120;
        if (c > 8) return mk(1'b1, 0, 0, 0, 0, 0, 0);
        bp = (c == 1) ? b : b + 24 * c;
        kp = tbl_ceil((bp + c - 1) / c);
        if (c == 1) begin
            km = 0; cm = 0;
        end else begin
            km = tbl_below(kp);
            cm = (c * kp - bp) / (kp - km);
        end
        cp = c - cm;
        return mk(1'b0, c, cp, cm, kp, km, cp * kp + cm * km - bp);
    endfunction

    task automatic send(input int b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        b_in = 16'(b);
        while (!in_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout b=%0d in_ready=%0d required 1", b, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!out_valid && n < 600) begin
            @(negedge clk);
            n++;
        end
        ok = out_valid;
    endtask

    task automatic accept_out();
        if (err) begin
`ifdef CB_SEG_ERR_CNT_EN
            exp_err_cnt++;
`endif
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        aclr = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs in_ready=%0d out_valid=%0d required 1/0", in_ready, out_valid);
        end
        aclr = 1'b0;
        exp_err_cnt = 0;
        @(negedge clk);
        checks++;
        if (observe() !== mk(1'b0, 0, 0, 0, 0, 0, 0) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_out got %s in_ready=%0d required all zero, in_ready=1", fmt(observe()), in_ready);
        end
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_cnt got %0d required 0", err_cnt);
        end
    endtask

    task automatic test_error();
        int   bs[2] = '{60000, 0};
        bit   ok;
        res_t e;
        foreach (bs[i]) begin
            exp_q.push_back(mk(1'b1, 0, 0, 0, 0, 0, 0));
            send(bs[i]);
            wait_out(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL err_timeout b=%0d out_valid=0 required 1", bs[i]);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe() !== e) begin
                    errors++;
                    $display("FAIL err_result b=%0d got %s required %s", bs[i], fmt(observe()), fmt(e));
                end
                accept_out();
            end
        end
        checks++;
        if (err_cnt !== 16'(exp_err_cnt)) begin
            errors++;
            $display("FAIL err_cnt got %0d required %0d", err_cnt, exp_err_cnt);
        end
    endtask

    task automatic test_table();
        int   bs[3] = '{6144, 6145, 12288};
        res_t es[3];
        bit   ok;
        res_t e;
        es[0] = mk(1'b0, 1, 1, 0, 6144, 0, 0);
        es[1] = mk(1'b0, 2, 1, 1, 3136, 3072, 15);
        es[2] = mk(1'b0, 3, 2, 1, 4160, 4096, 56);
        foreach (bs[i]) begin
            exp_q.push_back(es[i]);
            send(bs[i]);
            wait_out(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL table_timeout b=%0d out_valid=0 required 1", bs[i]);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe() !== e) begin
                    errors++;
                    $display("FAIL table_result b=%0d got %s required %s", bs[i], fmt(observe()), fmt(e));
                end
                accept_out();
            end
        end
    endtask

    task automatic test_back_to_back();
        fork
            begin
                exp_q.push_back(mk(1'b0, 1, 1, 0, 40, 0, 10));
                send(30);
                exp_q.push_back(mk(1'b0, 1, 1, 0, 1008, 0, 8));
                send(1000);
            end
            begin
                bit   ok;
                res_t e;
                wait_out(ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL b2b_first_timeout out_valid=0 required 1");
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_busy_ready in_ready=%0d required 0", in_ready);
                    end
                    for (int c = 0; c < 5; c++) begin
                        checks++;
                        if (observe() !== e || out_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL b2b_hold cycle=%0d got %s valid=%0d required %s valid=1",
                                     c, fmt(observe()), out_valid, fmt(e));
                        end
                        @(negedge clk);
                    end
                    accept_out();
                end
                wait_out(ok);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL b2b_second_timeout out_valid=0 required 1");
                end else if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (observe() !== e) begin
                        errors++;
                        $display("FAIL b2b_second got %s required %s", fmt(observe()), fmt(e));
                    end
                    accept_out();
                end
            end
        join
    endtask

    task automatic test_model_sweep();
        int   bs[10] = '{1, 39, 40, 512, 513, 1024, 6120, 6121, 48960, 48961};
        bit   ok;
        res_t e;
        foreach (bs[i]) begin
            exp_q.push_back(model(bs[i]));
            send(bs[i]);
            wait_out(ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL sweep_timeout b=%0d out_valid=0 required 1", bs[i]);
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (observe() !== e) begin
                    errors++;
                    $display("FAIL sweep_result b=%0d got %s required %s", bs[i], fmt(observe()), fmt(e));
                end
                accept_out();
            end
        end
        checks++;
        if (err_cnt !== 16'(exp_err_cnt)) begin
            errors++;
            $display("FAIL sweep_err_cnt got %0d required %0d", err_cnt, exp_err_cnt);
        end
    endtask

    task automatic test_abort();
        bit   ok;
        bit   seen = 1'b0;
        res_t e;
        send(6145);
        repeat (12) @(negedge clk);
        aclr = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset in_ready=%0d out_valid=%0d required 1/0", in_ready, out_valid);
        end
        @(negedge clk);
        aclr = 1'b0;
        exp_err_cnt = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_output out_valid seen=1 required 0");
        end
        checks++;
        if (in_ready !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL abort_idle in_ready=%0d err_cnt=%0d required 1/0", in_ready, err_cnt);
        end
        exp_q.push_back(mk(1'b0, 1, 1, 0, 40, 0, 0));
        send(40);
        wait_out(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_next_timeout out_valid=0 required 1");
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (observe() !== e) begin
                errors++;
                $display("FAIL abort_next got %s required %s", fmt(observe()), fmt(e));
            end
            accept_out();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        aclr      = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        b_in      = '0;
        test_reset();
        test_error();
        test_table();
        test_back_to_back();
        test_model_sweep();
        test_abort();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover size=%0d required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cb_seg_calc.md
Name: cb_seg_calc

Overview:
- Parametrised successor to the fixed-threshold segmentation size calculator.
- Takes a transport-block size B (CRC-attached) and computes the full turbo code-block segmentation:
  - C (number of code blocks);
  - K_plus and K_minus (sizes from the standard 40..6144 interleaver table);
  - C_plus and C_minus (how many blocks of each size);
  - F (filler bits).
- Uses an iterative multi-cycle datapath with valid/ready handshakes on both sides.
- Sits between the size FIFO and the segmentation/filler-insertion stage.

Parameters:
- B_W, 16, width of B and of F.
- Z, 6144, maximum code-block size.
- L, 24, per-block CRC length, added when C>1.
- MAX_C, 8, largest legal C; above this, err is raised.
- C_W, $clog2(MAX_C+1), width of the C, C_plus and C_minus outputs.

Ports:
- clk  in  1  clock.
- aclr  in  1  asynchronous reset, active-high.
- in_valid  in  1  B is presented.
- in_ready  out  1  block idle; B is accepted when in_valid&in_ready.
- b_in  in  B_W  transport-block size.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- c_out  out  C_W  C.
- c_plus  out  C_W  C+.
- c_minus  out  C_W  C-.
- k_plus  out  13  K+.
- k_minus  out  13  K-.
- filler  out  B_W  F.
- err  out  1  B==0 or C>MAX_C; valid with out_valid.
- err_cnt  out  16  saturating error count (see Optional Feature).

Behaviour:
- Reset state:
  - aclr asserted at any time forces state IDLE and all outputs to 0.
  - Exception: in_ready=1 during and after reset.
  - An in-flight computation is discarded with no output.
- K table (computed arithmetically, no ROM):
  - 40..512 step 8;
  - 528..1024 step 16;
  - 1056..2048 step 32;
  - 2112..6144 step 64.
  - next(K) and prev(K) use the step of the range the result falls in.
- FSM states:
  - IDLE:
    - in_ready=1.
    - On accept, latch B and go to DIVC.
  - DIVC:
    - If B<=Z: C=1, B'=B.
    - Else C=ceil(B/(Z-L)) by repeated subtraction (one subtraction per cycle), then B'=B+C*L.
    - If B==0 or C>MAX_C: go to DONE with err=1 and all other result fields 0.
  - KSRCH:
    - K starts at 40 and steps to next(K) each cycle until C*K>=B'.
    - K+ is the first K meeting that condition.
    - Internal products are at least B_W+C_W wide; no truncation.
  - SPLIT:
    - If C==1: C+=1, C-=0, K-=0.
    - Else: K-=prev(K+), dK=K+-K-, C- = floor((C*K+ - B')/dK) by repeated subtraction, C+=C-C-.
  - FILL:
    - F = C+*K+ + C-*K- - B'. One cycle.
  - DONE:
    - out_valid=1, outputs held stable.
    - On out_ready, return to IDLE.
    - in_ready is 0 in every state except IDLE.
- Latency:
  - Variable. Measured from accept to out_valid, it is at most 3+MAX_C+188+MAX_C cycles.
  - Back-to-back operation needs one IDLE cycle between results.
  - out_valid=1 with out_ready=1 in DONE returns to IDLE on the next cycle.
- Boundaries:
  - B<40 gives K+=40, F=40-B.
  - B==Z gives C=1, F=0.
  - in_valid while busy is ignored; upstream must hold the request.
  - Output fields must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: CB_SEG_ERR_CNT_EN.
- Defined:
  - err_cnt increments on each accepted result (out_valid&out_ready) with err=1.
  - Saturates at 16'hFFFF.
  - Cleared only by aclr.
- Undefined: err_cnt is tied to 0 and no counter logic is generated.

Test Plan:
- B=6144 -> C=1, C+=1, C-=0, K+=6144, K-=0, F=0, err=0.
- B=6145 -> C=2, C+=1, C-=1, K+=3136, K-=3072, F=15.
- B=12288 -> C=3, C+=2, C-=1, K+=4160, K-=4096, F=56.
- B=30, then B=1000 back-to-back -> (C=1, K+=40, F=10) then (C=1, K+=1008, F=8); out_ready held low for 5 cycles on the first result, which must remain stable.
- B=60000 (C=10>MAX_C) and B=0 -> err=1, other fields 0; with CB_SEG_ERR_CNT_EN, err_cnt=2.
- aclr pulsed during KSRCH of B=6145 -> no out_valid; in_ready=1; the next B=40 gives K+=40, F=0.
